// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package divider_pkg;

  localparam int unsigned DIV_WIDTH      = 32;
  localparam int unsigned DIV_ITERATIONS = 32;
  localparam int unsigned DIV_CNT_W      = 6;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StFinish
  } div_state_e;

  // Magnitude of an operand; only negated when the operation is signed.
  function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] value,
                                                   input logic                 is_signed);
    return (is_signed && value[DIV_WIDTH-1]) ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem, dq} left, trial-subtract, select.
module divider_step
  import divider_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem,
  input  logic [DIV_WIDTH-1:0] dq,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH:0]   rem_next,
  output logic [DIV_WIDTH-1:0] dq_next
);

  logic [DIV_WIDTH+1:0] shifted;
  logic [DIV_WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem, dq[DIV_WIDTH-1]};
    // One guard bit above the 33-bit remainder so the sign of the trial is exact.
    trial   = shifted - {2'b00, divisor};
    if (!trial[DIV_WIDTH+1]) begin
      rem_next = trial[DIV_WIDTH:0];
      dq_next  = {dq[DIV_WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[DIV_WIDTH:0];
      dq_next  = {dq[DIV_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential 32-bit signed/unsigned divider with start/busy/done handshake.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);

  div_state_e           state_q;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     dq_q;
  logic [WIDTH-1:0]     divisor_q;
  logic [DIV_CNT_W-1:0] count_q;
  logic                 neg_quot_q;
  logic                 neg_rem_q;
  logic                 dbz_q;

  logic [WIDTH:0]       rem_next;
  logic [WIDTH-1:0]     dq_next;

  divider_step u_step (
    .rem      (rem_q),
    .dq       (dq_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .dq_next  (dq_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      divByZero  <= 1'b0;
      rem_q      <= '0;
      dq_q       <= '0;
      divisor_q  <= '0;
      count_q    <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            neg_quot_q <= isSigned & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q  <= isSigned & dividend[WIDTH-1];
            rem_q      <= '0;
            count_q    <= '0;
            divisor_q  <= div_abs(divisor, isSigned);
            if (divisor == '0) begin
              // Keep the raw dividend: it is returned unmodified as the remainder.
              dbz_q   <= 1'b1;
              dq_q    <= dividend;
              state_q <= StFinish;
            end else begin
              dbz_q   <= 1'b0;
              dq_q    <= div_abs(dividend, isSigned);
              state_q <= StCompute;
            end
          end
        end

        StCompute: begin
          rem_q   <= rem_next;
          dq_q    <= dq_next;
          count_q <= count_q + 1'b1;
          if (count_q == DIV_CNT_W'(DIV_ITERATIONS - 1)) begin
            state_q <= StFinish;
          end
        end

        StFinish: begin
          done      <= 1'b1;
          divByZero <= dbz_q;
          if (dbz_q) begin
            quotient  <= DIV_BY_ZERO_QUOTIENT;
            remainder <= dq_q;
          end else begin
            quotient  <= neg_quot_q ? (~dq_q + 1'b1) : dq_q;
            remainder <= neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
          end
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a monitor checks on done.
module tb_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        isSigned = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  divider dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .isSigned  (isSigned),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic done_prev = 1'b0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      chk("done_single_cycle", {31'b0, done_prev}, 32'd0);
      chk("busy_with_done", {31'b0, busy}, 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("divByZero", {31'b0, divByZero}, {31'b0, e.dbz});
        chk("done_cycle", cyc, e.cyc);
      end
    end
    done_prev = reset ? 1'b0 : done;
  end

  // Called just after a negedge; start is sampled at the next posedge (edge k).
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                       input int lat);
    exp_t e;
    start = 1'b1; isSigned = s; dividend = a; divisor = b;
    @(posedge clock);
    #1;
    e.q = eq; e.r = er; e.dbz = edbz; e.cyc = cyc + lat;
    sb.push_back(e);
    start = 1'b0;
    dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  // Returns right after the negedge at which done is high.
  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) return;
    end
    chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_idle_after();
    @(negedge clock);
    chk("busy_cleared", {31'b0, busy}, 32'd0);
    chk("done_cleared", {31'b0, done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'b0, divByZero}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Unsigned and signed basics.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    wait_done(); check_idle_after();
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    wait_done(); check_idle_after();
    issue(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
    wait_done(); check_idle_after();

    // Divide by zero, both signednesses.
    issue(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    wait_done(); check_idle_after();
    issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    wait_done(); check_idle_after();

    // Signed overflow corner and its unsigned counterpart.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    wait_done(); check_idle_after();
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
    wait_done(); check_idle_after();

    // start while busy is ignored.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    repeat (10) @(negedge clock);
    start = 1'b1; isSigned = 1'b0; dividend = 32'd50; divisor = 32'd3;
    @(negedge clock);
    start = 1'b0;
    wait_done(); check_idle_after();

    // Back-to-back: second start lands on the done cycle.
    issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33);
    wait_done();
    issue(1'b1, 32'hFFFF_FFF0, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 33);
    wait_done(); check_idle_after();

    // Reset mid-operation discards the computation.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    #1;
    sb.delete();
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dbz", {31'b0, divByZero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("midrst_no_done", {31'b0, done}, 32'd0);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    wait_done(); check_idle_after();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential 32-bit integer divider for the single-core processor's execute stage, serving l.div and l.divu alongside the combinational adder/comparator unit. It computes quotient and remainder with a radix-2 restoring algorithm over 32 iteration cycles. It uses a start/busy/done handshake so the pipeline stalls while a division is in progress.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a division; sampled only in IDLE.
- isSigned  in  1  1 = two's-complement division (l.div), 0 = unsigned (l.divu); sampled with start.
- dividend  in  32  operand A; sampled with start.
- divisor  in  32  operand B; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done deasserts.
- done  out  1  single-cycle pulse when results are valid.
- quotient  out  32  result; held until the next accepted start.
- remainder  out  32  result; held until the next accepted start.
- divByZero  out  1  set with done when divisor was 0; held like the results.

## Operation
- States:
  - IDLE -> COMPUTE on start with divisor != 0.
  - IDLE -> FINISH on start with divisor == 0.
  - COMPUTE -> FINISH after 32 iterations.
  - FINISH -> IDLE unconditionally.
- Accept (IDLE and start):
  - Latch the magnitudes |dividend| and |divisor|, using absolute value only when isSigned.
  - Latch negQ = isSigned & (dividend[31] ^ divisor[31]) and negR = isSigned & dividend[31].
  - Clear partial remainder (33 bits) and iteration counter (6 bits).
- Each COMPUTE cycle:
  - Shift {rem, dq} left by one.
  - Trial = rem − divisor, computed 33 bits wide.
  - If trial is non-negative: rem = trial and quotient bit = 1; otherwise restore and quotient bit = 0.
  - Counter increments; the 32nd iteration moves to FINISH.
- FINISH:
  - Register quotient = negQ ? −q : q and remainder = negR ? −r : r.
  - Assert done and clear busy on the following edge.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend (unmodified), divByZero = 1.
- Signed overflow (0x80000000 / 0xFFFFFFFF): the magnitude path yields quotient = 0x80000000 and remainder = 0. No flag is raised.
- start while busy is ignored and does not queue.
- Operand changes after acceptance have no effect.
- Reset mid-operation: return to IDLE immediately and discard the computation.
- Reset values: busy = 0, done = 0, divByZero = 0, quotient = 0, remainder = 0, state = IDLE.

## Timing
- Let start be sampled high at edge k.
  - busy is high from after k through the cycle in which done is high.
  - Normal path: COMPUTE iterations occur on edges k+1..k+32; FINISH registers results at edge k+33; done is high between edges k+33 and k+34.
  - Divide by zero: FINISH at edge k+1; done is high between edges k+1 and k+2.
- A new start is accepted at the edge where done is high (state is IDLE there), giving back-to-back issue every 34 cycles.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the state encoding (IDLE, COMPUTE, FINISH)
  - DIV_WIDTH = 32
  - DIV_ITERATIONS = 32
  - the divide-by-zero quotient constant 0xFFFFFFFF
- The single submodule divider_step is natural: a combinational shift/trial-subtract/select of one iteration, instantiated once. The control FSM, counter and sign fix-up stay in divider.

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, divByZero 0; done exactly 33 cycles after the start edge, pulse one cycle wide.
- Signed −100 / 7 (0xFFFFFF9C / 7) → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Signed 100 / −7 → quotient 0xFFFFFFF2, remainder 2.
- 5 / 0, both signed and unsigned → quotient 0xFFFFFFFF, remainder 5, divByZero 1; done at start edge + 1.
- 0x80000000 / 0xFFFFFFFF:
  - signed → quotient 0x80000000, remainder 0
  - unsigned → quotient 0, remainder 0x80000000
- start pulsed at iteration 10 with new operands → ignored; first result unchanged. Back-to-back start on the done cycle → second result correct 33 cycles later.
- reset asserted at iteration 15 → busy and done drop immediately, outputs read 0. A subsequent 0xFFFFFFFF / 1 unsigned → quotient 0xFFFFFFFF, remainder 0.
